// File: rtl/ramp_conv_counter.sv
// Ramp/single-slope ADC conversion counter: counts clk cycles from start until the
// synchronised comparator trips or MAX_COUNT is reached, then offers the code on valid/ready.
module ramp_conv_counter #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT  = {WIDTH{1'b1}},
  parameter int              SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             comp,
  input  logic             result_ready,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Result handshake: a transfer happens on a rising edge where result_valid && result_ready;
  // while result_valid is high and result_ready is low, result and overflow hold steady.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_n;
  logic   comp_s;
  logic   at_max;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign comp_s = comp;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= (sync_q << 1) | SYNC_STAGES'(comp);
      end
      assign comp_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign at_max = (count == MAX_COUNT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = COUNT;
      COUNT: begin
        if (abort)                 state_n = IDLE;
        else if (comp_s || at_max) state_n = DONE;
      end
      DONE:    if (result_ready) state_n = start ? COUNT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath registers; comparator trip takes priority over the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) count <= '0;
        COUNT: begin
          if (abort) begin
            count <= '0;
          end else if (comp_s) begin
            result       <= count;
            overflow     <= 1'b0;
            result_valid <= 1'b1;
          end else if (at_max) begin
            result       <= MAX_COUNT;
            overflow     <= 1'b1;
            result_valid <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (start) count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_ramp_conv_counter.sv
// Bench for ramp_conv_counter: directed scenarios plus random traffic, all outputs
// compared every cycle against a cycle-level reference model.
module tb_ramp_conv_counter;

  localparam int W    = 8;
  localparam int MAXC = 255;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst, start, abort, comp, result_ready;
  logic [W-1:0] count, result;
  logic         result_valid, overflow, busy;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  ramp_conv_counter #(.WIDTH(W), .MAX_COUNT(8'(MAXC)), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .comp(comp),
    .result_ready(result_ready), .count(count), .result(result),
    .result_valid(result_valid), .overflow(overflow), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // reference model: phase 0 = idle, 1 = converting, 2 = holding a result
  int           m_phase = 0;
  int           m_count = 0;
  int           m_result = 0;
  bit           m_valid = 0;
  bit           m_ovf = 0;
  bit           hist [0:SYNC-1];

  always @(posedge clk) begin
    bit cs;
    if (rst) begin
      m_phase = 0; m_count = 0; m_result = 0; m_valid = 0; m_ovf = 0;
      for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
    end else begin
      cs = hist[SYNC-1];
      case (m_phase)
        0: if (start) begin m_phase = 1; m_count = 0; end
        1: begin
          if (abort) begin
            m_phase = 0; m_count = 0;
          end else if (cs) begin
            m_result = m_count; m_ovf = 0; m_valid = 1; m_phase = 2;
          end else if (m_count == MAXC) begin
            m_result = MAXC; m_ovf = 1; m_valid = 1; m_phase = 2;
          end else begin
            m_count = m_count + 1;
          end
        end
        default: if (result_ready) begin
          m_valid = 0;
          if (start) begin m_phase = 1; m_count = 0; end
          else m_phase = 0;
        end
      endcase
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = comp;
    end
  end

  // every-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("count",        32'(count),        32'(m_count));
      check("result",       32'(result),       32'(m_result));
      check("result_valid", 32'(result_valid), 32'(m_valid));
      check("overflow",     32'(overflow),     32'(m_ovf));
      check("busy",         32'(busy),         32'(m_phase != 0));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      if (result_valid) break;
      tick();
    end
    if (!result_valid) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic ack();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; comp = 1'b0; result_ready = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_busy",  32'(busy), 0);
    rst = 1'b0;

    // normal conversion: comp rises while count==20, seen two cycles later
    pulse_start();
    repeat (20) tick();
    comp = 1'b1;
    wait_valid(10, "norm");
    check("norm_result",   32'(result), 22);
    check("norm_overflow", 32'(overflow), 0);
    check("norm_count",    32'(count), 22);
    check("norm_model",    32'(m_result), 22);

    // back-pressure: start pulses in DONE are ignored
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      tick();
      check("bp_result", 32'(result), 22);
      check("bp_valid",  32'(result_valid), 1);
      check("bp_count",  32'(count), 22);
    end
    result_ready = 1'b1;
    tick();
    start = 1'b0; result_ready = 1'b0; comp = 1'b0;
    check("b2b_valid", 32'(result_valid), 0);
    check("b2b_count", 32'(count), 0);
    check("b2b_busy",  32'(busy), 1);
    // comp still high in the synchroniser, so this conversion captures 0
    wait_valid(5, "b2b");
    check("b2b_result", 32'(result), 0);
    ack();
    repeat (3) tick();

    // abort at count==50
    pulse_start();
    repeat (50) tick();
    check("abort_pre_count", 32'(count), 50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",   32'(busy), 0);
    check("abort_valid",  32'(result_valid), 0);
    check("abort_result", 32'(result), 0);

    // timeout with comp held low
    pulse_start();
    wait_valid(300, "tmo");
    check("tmo_result",   32'(result), 255);
    check("tmo_overflow", 32'(overflow), 1);
    check("tmo_count",    32'(count), 255);
    repeat (5) tick();
    check("tmo_hold_count", 32'(count), 255);
    check("tmo_hold_valid", 32'(result_valid), 1);
    ack();

    // comp already high when conversion starts
    comp = 1'b1;
    repeat (3) tick();
    pulse_start();
    wait_valid(5, "early");
    check("early_result",   32'(result), 0);
    check("early_overflow", 32'(overflow), 0);
    ack();
    comp = 1'b0;
    repeat (3) tick();

    // comp_s rises exactly at terminal count: comparator wins
    pulse_start();
    repeat (253) tick();
    comp = 1'b1;
    wait_valid(10, "edge");
    check("edge_result",   32'(result), 255);
    check("edge_overflow", 32'(overflow), 0);
    ack();
    comp = 1'b0;
    repeat (3) tick();

    // reset mid-conversion
    pulse_start();
    repeat (37) tick();
    check("rstmid_pre_count", 32'(count), 37);
    rst = 1'b1;
    tick();
    check("rstmid_count",  32'(count), 0);
    check("rstmid_result", 32'(result), 0);
    check("rstmid_busy",   32'(busy), 0);
    tick();
    rst = 1'b0;
    pulse_start();
    check("rstmid_restart_count", 32'(count), 0);
    check("rstmid_restart_busy",  32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      start        = ($urandom_range(0, 9) == 0);
      abort        = ($urandom_range(0, 39) == 0);
      result_ready = ($urandom_range(0, 2) != 0);
      rst          = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 14) == 0) comp = ~comp;
      tick();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
